// File: rtl/mm_pkg.sv
// Shared constants, part codes and state encoding for the matrix-multiply controller.
package mm_pkg;

    localparam int unsigned N          = 4;
    localparam int unsigned B_BASE     = 16;
    localparam int unsigned LOAD_BEATS = 32;
    localparam int unsigned PARTS      = 3;

    localparam logic [1:0] PART_LO  = 2'b00;
    localparam logic [1:0] PART_MID = 2'b01;
    localparam logic [1:0] PART_HI  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RDA,
        S_RDB,
        S_ACC,
        S_STORE,
        S_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/mm_idx_cnt.sv
// Cascaded k/j/i index counter: k steps inside a dot product, j/i step per result element.
module mm_idx_cnt #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc_k,
    input  logic         i_inc_ij,
    output logic [W-1:0] o_i,
    output logic [W-1:0] o_j,
    output logic [W-1:0] o_k,
    output logic         o_k_last,
    output logic         o_ij_last
);

    logic [W-1:0] r_i;
    logic [W-1:0] r_j;
    logic [W-1:0] r_k;

    // Advancing (i,j) restarts k; (N-1,N-1) wraps back to (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_inc_ij) begin
            r_k <= '0;
            if (r_j == W'(N - 1)) begin
                r_j <= '0;
                r_i <= (r_i == W'(N - 1)) ? '0 : r_i + W'(1);
            end else begin
                r_j <= r_j + W'(1);
            end
        end else if (i_inc_k) begin
            r_k <= r_k + W'(1);
        end
    end

    assign o_i       = r_i;
    assign o_j       = r_j;
    assign o_k       = r_k;
    assign o_k_last  = (r_k == W'(N - 1));
    assign o_ij_last = (r_i == W'(N - 1)) && (r_j == W'(N - 1));

endmodule

// File: rtl/mm_ctrl.sv
// Sequencer for the 4x4 matrix-multiply datapath: operand load, multiply-accumulate, byte-wise result stream.
module mm_ctrl #(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              memin_read,
    output logic              memin_write,
    output logic              memout_read,
    output logic              memout_write,
    output logic              Reswrite,
    output logic              Awrite,
    output logic              Bwrite,
    output logic              clearRes,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] memout_addr,
    output logic [1:0]        part
);

    import mm_pkg::*;

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_load_cnt;
    logic [1:0]          r_part;
    logic                w_cnt_clr;
    logic                w_load_inc;
    logic                w_part_adv;
    logic                w_inc_k;
    logic                w_inc_ij;
    logic                w_k_last;
    logic                w_ij_last;
    logic [IDX_W-1:0]    w_i;
    logic [IDX_W-1:0]    w_j;
    logic [IDX_W-1:0]    w_k;
    logic [ADDR_W-1:0]   w_a_addr;
    logic [ADDR_W-1:0]   w_b_addr;
    logic [ADDR_W-1:0]   w_c_addr;

    mm_idx_cnt #(.N(N), .W(IDX_W)) u_idx (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_inc_k   (w_inc_k),
        .i_inc_ij  (w_inc_ij),
        .o_i       (w_i),
        .o_j       (w_j),
        .o_k       (w_k),
        .o_k_last  (w_k_last),
        .o_ij_last (w_ij_last)
    );

    // The (i,j) pair doubles as the result index during the output stream.
    assign w_a_addr = ADDR_W'(32'(w_i) * N + 32'(w_k));
    assign w_b_addr = ADDR_W'(B_BASE + 32'(w_k) * N + 32'(w_j));
    assign w_c_addr = ADDR_W'(32'(w_i) * N + 32'(w_j));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_load_cnt <= '0;
            r_part     <= PART_LO;
        end else begin
            r_state <= w_next;
            if (w_cnt_clr) begin
                r_load_cnt <= '0;
            end else if (w_load_inc) begin
                r_load_cnt <= r_load_cnt + ADDR_W'(1);
            end
            if (w_cnt_clr) begin
                r_part <= PART_LO;
            end else if (w_part_adv) begin
                case (r_part)
                    PART_LO:  r_part <= PART_MID;
                    PART_MID: r_part <= PART_HI;
                    default:  r_part <= PART_LO;
                endcase
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_clr    = 1'b0;
        w_load_inc   = 1'b0;
        w_part_adv   = 1'b0;
        w_inc_k      = 1'b0;
        w_inc_ij     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        memin_read   = 1'b0;
        memin_write  = 1'b0;
        memout_read  = 1'b0;
        memout_write = 1'b0;
        Reswrite     = 1'b0;
        Awrite       = 1'b0;
        Bwrite       = 1'b0;
        clearRes     = 1'b0;
        addr         = '0;
        memout_addr  = '0;
        part         = PART_LO;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready    = 1'b1;
                addr        = r_load_cnt;
                memin_write = in_valid;
                if (in_valid) begin
                    w_load_inc = 1'b1;
                    if (r_load_cnt == ADDR_W'(LOAD_BEATS - 1)) begin
                        w_next = S_CLR;
                    end
                end
            end
            S_CLR: begin
                clearRes = 1'b1;
                w_next   = S_RDA;
            end
            S_RDA: begin
                addr       = w_a_addr;
                memin_read = 1'b1;
                Awrite     = 1'b1;
                w_next     = S_RDB;
            end
            S_RDB: begin
                addr       = w_b_addr;
                memin_read = 1'b1;
                Bwrite     = 1'b1;
                w_next     = S_ACC;
            end
            S_ACC: begin
                Reswrite = 1'b1;
                if (w_k_last) begin
                    w_next = S_STORE;
                end else begin
                    w_inc_k = 1'b1;
                    w_next  = S_RDA;
                end
            end
            S_STORE: begin
                memout_addr  = w_c_addr;
                memout_write = 1'b1;
                w_inc_ij     = 1'b1;
                w_next       = w_ij_last ? S_OUT : S_CLR;
            end
            S_OUT: begin
                memout_read = 1'b1;
                out_valid   = 1'b1;
                memout_addr = w_c_addr;
                part        = r_part;
                if (out_ready) begin
                    w_part_adv = 1'b1;
                    if (r_part == PART_HI) begin
                        w_inc_ij = 1'b1;
                        if (w_ij_last) begin
                            w_next = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mm_ctrl.sv
// Bench for mm_ctrl: behavioural datapath around the controller, table-driven jobs and control-sequence checks.
module tb_mm_ctrl;

    typedef struct {
        int a_kind;
        int b_kind;
        int in_gaps;
        int out_stall;
        int spur_start;
        int chk_ctrl;
        int rst_at;
        int exp_first;
        int exp_last;
    } job_t;

    typedef struct {
        int         cyc;
        logic [4:0] addr;
        logic [4:0] maddr;
        logic [7:0] stb;
    } ctl_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       memin_read;
    logic       memin_write;
    logic       memout_read;
    logic       memout_write;
    logic       Reswrite;
    logic       Awrite;
    logic       Bwrite;
    logic       clearRes;
    logic [4:0] addr;
    logic [4:0] memout_addr;
    logic [1:0] part;
    logic [7:0] in_data;
    logic [7:0] dataout;

    int n_checks;
    int n_err;
    int n_clr;
    int n_resw;
    int n_done;
    int n_busy;

    job_t jobs[6];
    ctl_t ctl[18];

    mm_ctrl #(.N(4), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .memin_read   (memin_read),
        .memin_write  (memin_write),
        .memout_read  (memout_read),
        .memout_write (memout_write),
        .Reswrite     (Reswrite),
        .Awrite       (Awrite),
        .Bwrite       (Bwrite),
        .clearRes     (clearRes),
        .addr         (addr),
        .memout_addr  (memout_addr),
        .part         (part)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: memories, operand registers and the accumulator.
    logic [7:0]  mem_in  [32];
    logic [17:0] mem_out [16];
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [17:0] res;

    always @(posedge clk) begin
        if (memin_write) mem_in[addr] <= in_data;
        if (Awrite && memin_read) ra <= mem_in[addr];
        if (Bwrite && memin_read) rb <= mem_in[addr];
        if (clearRes) res <= '0;
        else if (Reswrite) res <= res + 18'(ra) * 18'(rb);
        if (memout_write) mem_out[memout_addr[3:0]] <= res;
    end

    always_comb begin
        dataout = 8'h00;
        if (memout_read) begin
            case (part)
                2'b00:   dataout = mem_out[memout_addr[3:0]][7:0];
                2'b01:   dataout = mem_out[memout_addr[3:0]][15:8];
                2'b10:   dataout = {6'b0, mem_out[memout_addr[3:0]][17:16]};
                default: dataout = 8'h00;
            endcase
        end
    end

    // Free-running strobe counters; jobs take differences.
    always @(negedge clk) begin
        #2;
        if (clearRes) n_clr  <= n_clr + 1;
        if (Reswrite) n_resw <= n_resw + 1;
        if (done)     n_done <= n_done + 1;
        if (busy)     n_busy <= n_busy + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] all_outs();
        return {busy, in_ready, out_valid, done, memin_read, memin_write, memout_read,
                memout_write, Reswrite, Awrite, Bwrite, clearRes, addr, memout_addr, part};
    endfunction

    function automatic logic [7:0] fill(input int kind, input int idx);
        case (kind)
            0:       return (idx / 4 == idx % 4) ? 8'd1 : 8'd0;
            1:       return 8'(idx + 1);
            2:       return 8'hFF;
            3:       return 8'd2;
            4:       return 8'd3;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic int byte_of(input int v, input int p);
        if (p == 0) return v & 255;
        if (p == 1) return (v >> 8) & 255;
        return (v >> 16) & 3;
    endfunction

    task automatic run_job(input job_t j, input int id);
        logic [7:0] va [32];
        int exp_c [16];
        int obs   [16];
        int beats, cyc, nb, ti, stall_left, e, p;
        int clr0, rw0, dn0, bz0;
        logic tog;
        logic [14:0] held;
        for (int x = 0; x < 16; x++) begin
            va[x]      = fill(j.a_kind, x);
            va[16 + x] = fill(j.b_kind, x);
            obs[x]     = 0;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp_c[r*4+c] = 0;
                for (int k = 0; k < 4; k++)
                    exp_c[r*4+c] += int'(va[r*4+k]) * int'(va[16+k*4+c]);
            end
        clr0 = n_clr; rw0 = n_resw; dn0 = n_done; bz0 = n_busy;

        // Load phase
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk($sformatf("job%0d in_ready_after_start", id), 64'(in_ready), 64'd1);
        beats = 0; cyc = 0; tog = 1'b0;
        while (beats < 32 && cyc < 200) begin
            in_valid = (j.in_gaps != 0) ? tog : 1'b1;
            tog      = ~tog;
            in_data  = va[beats];
            start    = (j.spur_start != 0 && beats == 10);
            #1;
            if (in_valid && in_ready) beats++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (beats < 32) begin
            chk($sformatf("job%0d load_timeout", id), 64'(beats), 64'd32);
            return;
        end

        // Compute phase: 224 cycles, optional control-sequence table and reset injection
        ti = 0;
        for (int cc = 0; cc < 224; cc++) begin
            if (cc == j.rst_at) begin
                rst = 1'b1;
                #1;
                chk($sformatf("job%0d outs_zero_in_rst", id), 64'(all_outs()), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk($sformatf("job%0d idle_after_rst", id), 64'({busy, in_ready, out_valid}), 64'd0);
                @(negedge clk);
                return;
            end
            #1;
            while (j.chk_ctrl != 0 && ti < 18 && ctl[ti].cyc == cc) begin
                chk($sformatf("job%0d ctl_cyc%0d", id, cc),
                    64'({addr, memout_addr, memin_read, memin_write, memout_read, memout_write,
                         Reswrite, Awrite, Bwrite, clearRes}),
                    64'({ctl[ti].addr, ctl[ti].maddr, ctl[ti].stb}));
                ti++;
            end
            @(negedge clk);
        end

        // Output phase
        nb = 0; cyc = 0; held = '0;
        stall_left = (j.out_stall != 0) ? 5 : 0;
        #1;
        chk($sformatf("job%0d first_out", id),
            64'({out_valid, memout_read, memout_addr, part}), 64'({1'b1, 1'b1, 5'd0, 2'b00}));
        while (nb < 48 && cyc < 400) begin
            out_ready = !(stall_left > 0 && out_valid && part == 2'b01 && memout_addr == 5'd5);
            start     = (j.spur_start != 0 && nb == 20);
            #1;
            if (!out_ready) begin
                if (stall_left == 5) held = {out_valid, dataout, part, memout_addr[3:0]};
                else chk($sformatf("job%0d stall_hold", id),
                         64'({out_valid, dataout, part, memout_addr[3:0]}), 64'(held));
                stall_left--;
            end
            if (out_valid && out_ready) begin
                e = nb / 3;
                p = nb % 3;
                chk($sformatf("job%0d byte%0d", id, nb), 64'(dataout), 64'(byte_of(exp_c[e], p)));
                obs[e] = obs[e] | (int'(dataout) << (8 * p));
                nb++;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (nb < 48) begin
            chk($sformatf("job%0d out_timeout", id), 64'(nb), 64'd48);
            return;
        end
        #1;
        chk($sformatf("job%0d done_pulse", id), 64'(done), 64'd1);
        @(negedge clk);
        #3;
        chk($sformatf("job%0d idle_end", id), 64'({done, busy}), 64'd0);
        chk($sformatf("job%0d done_count", id), 64'(n_done - dn0), 64'd1);
        chk($sformatf("job%0d clearRes_count", id), 64'(n_clr - clr0), 64'd16);
        chk($sformatf("job%0d Reswrite_count", id), 64'(n_resw - rw0), 64'd64);
        if (j.in_gaps == 0 && j.out_stall == 0)
            chk($sformatf("job%0d total_cycles", id), 64'(1 + n_busy - bz0), 64'd306);
        if (j.exp_first >= 0) begin
            chk($sformatf("job%0d elem0", id), 64'(obs[0]), 64'(j.exp_first));
            chk($sformatf("job%0d elem15", id), 64'(obs[15]), 64'(j.exp_last));
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        n_clr = 0; n_resw = 0; n_done = 0; n_busy = 0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;

        //            a  b  gap stl spur ctl rst  first   last
        jobs[0] = '{0, 1, 0, 0, 0, 1, -1, 1,      16};
        jobs[1] = '{2, 2, 0, 0, 0, 0, -1, 260100, 260100};
        jobs[2] = '{0, 1, 1, 1, 0, 0, -1, 1,      16};
        jobs[3] = '{3, 4, 0, 0, 1, 0, -1, 24,     24};
        jobs[4] = '{5, 5, 0, 0, 0, 0, 100, -1,    -1};
        jobs[5] = '{5, 5, 0, 0, 0, 1, -1, -1,     -1};

        // Compute-phase control vectors: cycle, addr, memout_addr, strobes
        // strobes = {memin_read, memin_write, memout_read, memout_write, Reswrite, Awrite, Bwrite, clearRes}
        ctl[0]  = '{0,   5'd0,  5'd0,  8'b0000_0001};
        ctl[1]  = '{1,   5'd0,  5'd0,  8'b1000_0100};
        ctl[2]  = '{2,   5'd16, 5'd0,  8'b1000_0010};
        ctl[3]  = '{3,   5'd0,  5'd0,  8'b0000_1000};
        ctl[4]  = '{4,   5'd1,  5'd0,  8'b1000_0100};
        ctl[5]  = '{5,   5'd20, 5'd0,  8'b1000_0010};
        ctl[6]  = '{10,  5'd3,  5'd0,  8'b1000_0100};
        ctl[7]  = '{11,  5'd28, 5'd0,  8'b1000_0010};
        ctl[8]  = '{12,  5'd0,  5'd0,  8'b0000_1000};
        ctl[9]  = '{13,  5'd0,  5'd0,  8'b0001_0000};
        ctl[10] = '{14,  5'd0,  5'd0,  8'b0000_0001};
        ctl[11] = '{16,  5'd17, 5'd0,  8'b1000_0010};
        ctl[12] = '{71,  5'd4,  5'd0,  8'b1000_0100};
        ctl[13] = '{72,  5'd17, 5'd0,  8'b1000_0010};
        ctl[14] = '{83,  5'd0,  5'd5,  8'b0001_0000};
        ctl[15] = '{220, 5'd15, 5'd0,  8'b1000_0100};
        ctl[16] = '{221, 5'd31, 5'd0,  8'b1000_0010};
        ctl[17] = '{223, 5'd0,  5'd15, 8'b0001_0000};

        @(negedge clk);
        #1;
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            run_job(jobs[t], t);
            repeat (2) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mm_ctrl.md
# mm_ctrl

Control unit for the 4x4 matrix-multiply engine; drives every control input of the `dp` datapath. It sequences three phases:
- loading both 8-bit operand matrices into the input memory through a valid/ready stream;
- computing the 16 18-bit dot products with the shared multiplier/accumulator;
- streaming the results back out as 48 bytes through the datapath's `part` byte selector with a valid/ready handshake.

## Interface
- `N`, 4: matrix dimension; `2*N*N` must not exceed 32.
- `ADDR_W`, 5: memory address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a job; sampled only in IDLE.
- `in_valid`  in  1  `in_data` (wired directly to `dp.data_in`) is valid this cycle.
- `in_ready`  out  1  controller accepts an input byte this cycle.
- `out_ready`  in  1  downstream consumes `Dataout` this cycle.
- `out_valid`  out  1  `dp.Dataout` holds a result byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final output byte is accepted.
- `memin_read`, `memin_write`, `memout_read`, `memout_write`, `Reswrite`, `Awrite`, `Bwrite`, `clearRes`  out  1 each  datapath strobes.
- `addr`  out  5  input-memory address.
- `memout_addr`  out  5  output-memory address.
- `part`  out  2  byte select: 00 = bits 7:0, 01 = bits 15:8, 10 = {6'b0, bits 17:16}.

## Operation
- Memory writes are synchronous. Memory reads are combinational while the read enable is high. `A`, `B` and `Res` capture on the edge when their write strobe is high.
- Memory map:
  - Matrix A is stored row-major at memin 0..15; element A[i][k] is at address i*4+k.
  - Matrix B is stored row-major at memin 16..31; element B[k][j] is at address 16+k*4+j.
  - Result C[i][j] is stored at memout i*4+j.
- States: IDLE, LOAD, CLR, RDA, RDB, ACC, STORE, OUT, DONE.
- IDLE:
  - All strobes are low.
  - `start` moves to LOAD and zeroes the load counter and the i/j/k counters.
- LOAD:
  - `in_ready` = 1; `addr` = load count; `memin_write` = `in_valid`.
  - Each accepted beat increments the count.
  - After the 32nd beat, go to CLR.
  - Idle cycles (`in_valid` = 0) are allowed and write nothing.
- CLR: `clearRes` = 1, then RDA.
- RDA: `addr` = A address; `memin_read` = 1; `Awrite` = 1; then RDB.
- RDB: `addr` = B address; `memin_read` = 1; `Bwrite` = 1; then ACC.
- ACC: `Reswrite` = 1. If k < 3, increment k and return to RDA; otherwise go to STORE.
- STORE:
  - `memout_addr` = i*4+j; `memout_write` = 1; k is reset to 0.
  - If (i,j) is (3,3), go to OUT with index 0 and part 00.
  - Otherwise advance j, wrapping to 0 and incrementing i, then go to CLR.
- OUT:
  - `memout_read` = 1; `out_valid` = 1; `memout_addr` = index; `part` as defined above.
  - On `out_ready`, part advances 00 -> 01 -> 10; after 10 it returns to 00 and the index increments.
  - After the beat for index 15 with part 10 is accepted, go to DONE.
  - Without `out_ready`, all outputs hold.
- DONE: `done` = 1 for one cycle, then IDLE.
- Accumulation width: the datapath sums four 16-bit products into 18 bits. The maximum value is 4*255*255 = 260100, so there is no overflow and no saturation logic.
- `start` outside IDLE is ignored.
- `rst` at any time: go to IDLE immediately. All outputs go to 0, including `addr`, `memout_addr`, `part`, `in_ready`, `out_valid`, `busy` and `done`. Counters clear. Memory contents are untouched.

## Timing
- The cycle after a `start` edge: `in_ready` = 1.
- Load phase: 32 cycles minimum; one extra cycle per `in_valid` gap.
- Compute phase: exactly 14 cycles per element (1 + 4*3 + 1), 224 cycles in total from leaving LOAD to entering OUT.
- Output phase: 48 cycles minimum, one byte per cycle while `out_ready` = 1.
- `done` asserts the cycle after the last output handshake.
- A full job without stalls takes 1 + 32 + 224 + 48 + 1 cycles from `start`.
- `out_valid` never drops once asserted until its byte is accepted; `part` and `memout_addr` are stable throughout.

## Structure
- Package `mm_pkg` holds:
  - the state enum;
  - `N` = 4, `B_BASE` = 16, `LOAD_BEATS` = 32, `PARTS` = 3;
  - part codes `PART_LO`, `PART_MID`, `PART_HI`.
- Sub-module `mm_idx_cnt`: the cascaded k/j/i counter, with a terminal-count flag and synchronous clear.
- The FSM and output decode stay in `mm_ctrl`.
- All outputs come from registered state plus combinational decode.

## Test plan
- **Identity test:** A = identity, B = 1..16 -> the 48 output bytes are, per element, (value, 0x00, 0x00) for values 1..16 in row-major order; `done` pulses once.
- **Maximum values:** all 32 inputs 0xFF -> every element streams 0x04, 0xF8, 0x03 (260100 = 0x3F804).
- **Input and output stalls:** `in_valid` toggling every other cycle, and `out_ready` low for 5 cycles mid-part-01 -> results are identical, and `Dataout`/`part`/`memout_addr` are held stable during the stall.
- **Reset mid-compute:** assert `rst` at compute cycle 100 -> all outputs read 0 in that same cycle; a following job with new data produces correct results.
- **Spurious start:** pulse `start` during LOAD and during OUT -> no effect; total cycle count equals 306 without stalls.
- **Compute strobe ordering:** A all 2s, B all 3s -> every element streams 0x18, 0x00, 0x00. `clearRes` pulses exactly 16 times and `Reswrite` exactly 64 times.
